iob_sram_port_arbiter: RTL and testbench
========================================

Name: iob_sram_port_arbiter

Overview:
- Shares one simple-dual-port IOB SRAM (write port A, read port B, byte-enabled, 1-cycle read latency) between two write requesters and two read requesters.
- Each port has its own round-robin arbiter and a registered SRAM command stage.
- A read-response pipeline returns data to the granted reader.
- Same-cycle write/read address collisions are resolved by stalling the read.

Parameters:
- AW, 12, SRAM address width (depth 2**AW).
- DW, 256, data width.
- BW, DW/8, byte-enable width (derived, not overridable).

Ports:
- clk  in  1  single clock for all logic and both SRAM ports
- rst  in  1  synchronous, active-high reset
- w0_req, w1_req  in  1  write request; hold stable until grant
- w0_addr, w1_addr  in  AW  write address
- w0_data, w1_data  in  DW  write data
- w0_be, w1_be  in  BW  byte enables
- w0_gnt, w1_gnt  out  1  write accepted this cycle
- r0_req, r1_req  in  1  read request; hold stable until grant
- r0_addr, r1_addr  in  AW  read address
- r0_gnt, r1_gnt  out  1  read accepted this cycle
- r0_rvalid, r1_rvalid  out  1  read data valid (single-cycle pulse)
- r0_rdata, r1_rdata  out  DW  read data
- sram_ena, sram_wea  out  1  port A enable, write enable
- sram_be  out  BW  port A byte enables
- sram_addra  out  AW  port A address
- sram_dina  out  DW  port A data
- sram_enb  out  1  port B enable
- sram_addrb  out  AW  port B address
- sram_doutb  in  DW  port B data, valid the cycle after sram_enb

Behaviour:
- Grants:
  - Combinational from current requests and arbiter state.
  - At most one write grant and one read grant per cycle.
  - Requester may keep req high for back-to-back transfers; each grant cycle consumes one transfer.
- Round robin, per port:
  - Each port has a 1-bit last-winner pointer; reset value 1, so requester 0 wins the first contention.
  - If only one requester is asking, it wins.
  - If both are asking, the requester that is not the last winner wins.
  - The pointer updates only on a grant.
- Write path:
  - Grant in cycle T latches the winner's addr/data/be into the port A register.
  - In T+1: sram_ena=sram_wea=1 and sram_be=winner be; the SRAM commits at the end of T+1.
  - In idle cycles sram_ena=sram_wea=0; addr/data/be hold their last value.
- Read path:
  - Grant in cycle T registers addr plus a 1-bit owner tag.
  - In T+1: sram_enb=1 with sram_addrb.
  - In T+2: the owner's rN_rvalid=1 and rN_rdata=sram_doutb, passed through combinationally. The other reader's rvalid is 0.
  - Grant-to-rvalid latency is exactly 2 cycles, with no backpressure: readers must accept rvalid.
  - Sustained throughput is 1 read/cycle, with pipelined overlap.
  - rN_rdata is don't-care when rN_rvalid=0; the bench checks it only when rvalid=1.
- Collision:
  - Triggered when the winning read address equals the winning write address in the same cycle (full-address match, be ignored).
  - The read grant is withheld; the read pointer and read pipeline are unchanged.
  - The write is granted normally. The read retries next cycle and returns the new data.
  - Reads granted after the cycle of a write's grant observe that write.
- Reset:
  - All gnt=0, sram_ena=sram_wea=sram_enb=0, both rvalid=0.
  - Read pipeline valid/tag bits cleared; both pointers set to 1.
  - A reset asserted mid-transaction drops in-flight reads: no rvalid after reset for pre-reset grants.
  - A write granted in the cycle rst is asserted is not performed.
- Simultaneous events:
  - Write and read to different addresses in the same cycle are both granted.
  - A requester that drops req before grant is not granted; no state changes.

Test Plan:
- Single write then read: w0 writes addr 0x010, data pattern A, be all-ones, at T. r0 reads 0x010 at T+1 -> r0_gnt at T+1, r0_rvalid at T+3 with data A, r1_rvalid stays 0.
- Write contention after reset: w0 and w1 both request continuously for 4 cycles -> grants alternate w0,w1,w0,w1. sram_addra follows each grant one cycle later.
- Read contention and pipelining: r0/r1 read 0x001/0x002 continuously -> grants alternate r0,r1,... Each rvalid appears 2 cycles after its grant on the correct owner, with the correct preloaded data, at 1 result/cycle.
- Collision: same cycle, w1 writes 0x0A5 data B while r0 reads 0x0A5 -> w1_gnt=1, r0_gnt=0. Next cycle r0_gnt=1; 2 cycles later r0_rdata=B.
- Byte enables: preload 0x020 with all 0xFF. Write 0x00 with be=0x0000_0001 -> readback has byte 0 = 0x00 and bytes 1..31 = 0xFF.
- Reset mid-read: grant r1 at T, assert rst at T+1 -> r1_rvalid never asserted. After rst deasserts, all outputs are 0, and the first contention on each port grants requester 0.

Source files
------------

// File: rtl/iob_sram_port_arbiter_if.sv
// iob_sram_port_arbiter_if: requester and SRAM bus bundle for the arbiter; slave = arbiter side, master = requesters + SRAM side
interface iob_sram_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 256
);
  localparam int BW = DW / 8;
  logic          w0_req, w1_req;
  logic [AW-1:0] w0_addr, w1_addr;
  logic [DW-1:0] w0_data, w1_data;
  logic [BW-1:0] w0_be, w1_be;
  logic          w0_gnt, w1_gnt;
  logic          r0_req, r1_req;
  logic [AW-1:0] r0_addr, r1_addr;
  logic          r0_gnt, r1_gnt;
  logic          r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          sram_ena, sram_wea;
  logic [BW-1:0] sram_be;
  logic [AW-1:0] sram_addra;
  logic [DW-1:0] sram_dina;
  logic          sram_enb;
  logic [AW-1:0] sram_addrb;
  logic [DW-1:0] sram_doutb;
  modport slave (
    input  w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data, w0_be, w1_be,
    input  r0_req, r1_req, r0_addr, r1_addr, sram_doutb,
    output w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
    output sram_ena, sram_wea, sram_be, sram_addra, sram_dina, sram_enb, sram_addrb
  );
  modport master (
    output w0_req, w1_req, w0_addr, w1_addr, w0_data, w1_data, w0_be, w1_be,
    output r0_req, r1_req, r0_addr, r1_addr, sram_doutb,
    input  w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
    input  sram_ena, sram_wea, sram_be, sram_addra, sram_dina, sram_enb, sram_addrb
  );
endinterface

// File: rtl/iob_sram_port_arbiter.sv
// iob_sram_port_arbiter: two writers and two readers sharing a simple-dual-port SRAM via round-robin arbiters; clk/rst plain, everything else on bus
module iob_sram_port_arbiter #(
  parameter int AW = 12,
  parameter int DW = 256
) (
  input logic clk,
  input logic rst,
  iob_sram_port_arbiter_if.slave bus
);
  localparam int BW = DW / 8;
  logic          w_any, w_sel, w_go, r_any, r_sel, r_go, col;
  logic [AW-1:0] w_addr, r_addr;
  logic          w_last_q, w_last_d, r_last_q, r_last_d;
  logic          ena_q, ena_d, enb_q, enb_d, tag_q, tag_d, rv_q, rv_d, rtag_q, rtag_d;
  logic [AW-1:0] addra_q, addra_d, addrb_q, addrb_d;
  logic [DW-1:0] dina_q, dina_d;
  logic [BW-1:0] be_q, be_d;
  always_comb begin
    w_any    = bus.w0_req | bus.w1_req;
    w_sel    = (bus.w0_req & bus.w1_req) ? ~w_last_q : bus.w1_req;
    w_addr   = w_sel ? bus.w1_addr : bus.w0_addr;
    r_any    = bus.r0_req | bus.r1_req;
    r_sel    = (bus.r0_req & bus.r1_req) ? ~r_last_q : bus.r1_req;
    r_addr   = r_sel ? bus.r1_addr : bus.r0_addr;
    // a read to the address being written this cycle would race the commit; hold it one cycle
    col      = w_any & r_any & (r_addr == w_addr);
    w_go     = w_any & ~rst;
    r_go     = r_any & ~col & ~rst;
    w_last_d = w_go ? w_sel : w_last_q;
    r_last_d = r_go ? r_sel : r_last_q;
    ena_d    = w_go;
    addra_d  = w_go ? w_addr : addra_q;
    dina_d   = w_go ? (w_sel ? bus.w1_data : bus.w0_data) : dina_q;
    be_d     = w_go ? (w_sel ? bus.w1_be : bus.w0_be) : be_q;
    enb_d    = r_go;
    addrb_d  = r_go ? r_addr : addrb_q;
    tag_d    = r_go ? r_sel : tag_q;
    rv_d     = enb_q;
    rtag_d   = tag_q;
  end
  always_ff @(posedge clk) begin
    addra_q <= addra_d;
    dina_q  <= dina_d;
    be_q    <= be_d;
    addrb_q <= addrb_d;
    if (rst) begin
      w_last_q <= 1'b1;
      r_last_q <= 1'b1;
      ena_q    <= 1'b0;
      enb_q    <= 1'b0;
      tag_q    <= 1'b0;
      rv_q     <= 1'b0;
      rtag_q   <= 1'b0;
    end else begin
      w_last_q <= w_last_d;
      r_last_q <= r_last_d;
      ena_q    <= ena_d;
      enb_q    <= enb_d;
      tag_q    <= tag_d;
      rv_q     <= rv_d;
      rtag_q   <= rtag_d;
    end
  end
  assign bus.w0_gnt     = w_go & ~w_sel;
  assign bus.w1_gnt     = w_go & w_sel;
  assign bus.r0_gnt     = r_go & ~r_sel;
  assign bus.r1_gnt     = r_go & r_sel;
  assign bus.sram_ena   = ena_q;
  assign bus.sram_wea   = ena_q;
  assign bus.sram_be    = be_q;
  assign bus.sram_addra = addra_q;
  assign bus.sram_dina  = dina_q;
  assign bus.sram_enb   = enb_q;
  assign bus.sram_addrb = addrb_q;
  assign bus.r0_rvalid  = rv_q & ~rtag_q;
  assign bus.r1_rvalid  = rv_q & rtag_q;
  assign bus.r0_rdata   = bus.sram_doutb;
  assign bus.r1_rdata   = bus.sram_doutb;
endmodule

// File: tb/tb_iob_sram_port_arbiter.sv
// tb_iob_sram_port_arbiter: directed and random stimulus checked against a transaction-level model with an SRAM behavioural model
module tb_iob_sram_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 256;
  localparam int BW = DW / 8;
  typedef struct {
    int            due;
    bit            own;
    logic [DW-1:0] d;
  } rd_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  iob_sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  iob_sram_port_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  bit [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (bus.sram_enb) bus.sram_doutb <= mem[bus.sram_addrb];
    if (bus.sram_ena && bus.sram_wea)
      for (int i = 0; i < BW; i++)
        if (bus.sram_be[i]) mem[bus.sram_addra][i*8 +: 8] <= bus.sram_dina[i*8 +: 8];
  end
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;
  int wp = 1;
  int rp = 1;
  bit exp_ena = 1'b0;
  bit exp_enb = 1'b0;
  logic [AW-1:0] exp_addra, exp_addrb;
  logic [DW-1:0] exp_dina;
  logic [BW-1:0] exp_be;
  bit [DW-1:0] sh [2**AW];
  rd_t q[$];
  bit g_w0, g_w1, g_r0, g_r1;
  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction
  task automatic step();
    bit w0, w1, r0, r1, ws, rs, wg, rg, v0, v1, own;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] ed, wd;
    logic [BW-1:0] wb;
    #2;
    w0 = bus.w0_req; w1 = bus.w1_req; r0 = bus.r0_req; r1 = bus.r1_req;
    ws = (w0 && w1) ? (wp == 0) : w1;
    rs = (r0 && r1) ? (rp == 0) : r1;
    wa = ws ? bus.w1_addr : bus.w0_addr;
    ra = rs ? bus.r1_addr : bus.r0_addr;
    wd = ws ? bus.w1_data : bus.w0_data;
    wb = ws ? bus.w1_be : bus.w0_be;
    wg = (w0 || w1) && !rst;
    rg = (r0 || r1) && !rst && !((w0 || w1) && ra == wa);
    g_w0 = wg && !ws; g_w1 = wg && ws; g_r0 = rg && !rs; g_r1 = rg && rs;
    chk("w0_gnt", bus.w0_gnt, g_w0);
    chk("w1_gnt", bus.w1_gnt, g_w1);
    chk("r0_gnt", bus.r0_gnt, g_r0);
    chk("r1_gnt", bus.r1_gnt, g_r1);
    if (armed) begin
      chk("sram_ena", bus.sram_ena, exp_ena);
      chk("sram_wea", bus.sram_wea, exp_ena);
      if (exp_ena) begin
        chk("sram_addra", bus.sram_addra, exp_addra);
        chk("sram_dina", bus.sram_dina, exp_dina);
        chk("sram_be", bus.sram_be, exp_be);
      end
      chk("sram_enb", bus.sram_enb, exp_enb);
      if (exp_enb) chk("sram_addrb", bus.sram_addrb, exp_addrb);
      v0 = 0; v1 = 0; ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        own = q[0].own; ed = q[0].d; void'(q.pop_front());
        v0 = !own; v1 = own;
      end
      chk("r0_rvalid", bus.r0_rvalid, v0);
      chk("r1_rvalid", bus.r1_rvalid, v1);
      if (v0) chk("r0_rdata", bus.r0_rdata, ed);
      if (v1) chk("r1_rdata", bus.r1_rdata, ed);
    end
    if (rst) begin
      q.delete(); exp_ena = 0; exp_enb = 0; wp = 1; rp = 1;
    end else begin
      exp_enb = rg;
      if (rg) begin
        exp_addrb = ra; rp = rs ? 1 : 0;
        q.push_back('{cyc + 2, rs, sh[ra]});
      end
      exp_ena = wg;
      if (wg) begin
        exp_addra = wa; exp_dina = wd; exp_be = wb; wp = ws ? 1 : 0;
        for (int i = 0; i < BW; i++) if (wb[i]) sh[wa][i*8 +: 8] = wd[i*8 +: 8];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic setw(int p, bit req, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] b);
    if (p == 0) begin bus.w0_req = req; bus.w0_addr = a; bus.w0_data = d; bus.w0_be = b; end
    else begin bus.w1_req = req; bus.w1_addr = a; bus.w1_data = d; bus.w1_be = b; end
  endtask
  task automatic setr(int p, bit req, logic [AW-1:0] a);
    if (p == 0) begin bus.r0_req = req; bus.r0_addr = a; end
    else begin bus.r1_req = req; bus.r1_addr = a; end
  endtask
  task automatic idle();
    setw(0, 0, '0, '0, '0); setw(1, 0, '0, '0, '0); setr(0, 0, '0); setr(1, 0, '0);
  endtask
  logic [DW-1:0] pat_a, pat_b, d1, d2, ones;
  initial begin
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'h5A5A_00B0}};
    d1 = {8{32'h1111_0001}};
    d2 = {8{32'h2222_0002}};
    ones = '1;
    idle();
    rst = 1;
    step();
    armed = 1;
    step();
    rst = 0;
    step();
    setw(0, 1, 12'h010, pat_a, '1); step();
    setw(0, 0, '0, '0, '0); setr(0, 1, 12'h010); step();
    setr(0, 0, '0); repeat (3) step();
    rst = 1; step(); rst = 0;
    setw(0, 1, 12'h100, d1, '1); setw(1, 1, 12'h101, d2, '1);
    repeat (4) step();
    idle(); repeat (2) step();
    setw(0, 1, 12'h001, d1, '1); setw(1, 1, 12'h002, d2, '1); repeat (2) step();
    idle(); setr(0, 1, 12'h001); setr(1, 1, 12'h002); repeat (6) step();
    idle(); repeat (2) step();
    setw(1, 1, 12'h0A5, pat_b, '1); setr(0, 1, 12'h0A5); step();
    setw(1, 0, '0, '0, '0); step();
    setr(0, 0, '0); repeat (3) step();
    setw(0, 1, 12'h020, ones, '1); step();
    setw(0, 1, 12'h020, '0, 32'h0000_0001); step();
    setw(0, 0, '0, '0, '0); setr(1, 1, 12'h020); step();
    setr(1, 0, '0); repeat (3) step();
    setr(1, 1, 12'h300); step();
    setr(1, 0, '0); rst = 1; step();
    rst = 0; repeat (3) step();
    setw(0, 1, 12'h400, d1, '1); setw(1, 1, 12'h401, d2, '1);
    setr(0, 1, 12'h500); setr(1, 1, 12'h501); repeat (2) step();
    idle(); repeat (3) step();
    repeat (600) begin
      if (g_w0 || !bus.w0_req || $urandom_range(15) == 0)
        setw(0, 1'($urandom_range(1)), AW'($urandom_range(15)), rnd_dw(), BW'($urandom()));
      if (g_w1 || !bus.w1_req || $urandom_range(15) == 0)
        setw(1, 1'($urandom_range(1)), AW'($urandom_range(15)), rnd_dw(), BW'($urandom()));
      if (g_r0 || !bus.r0_req || $urandom_range(15) == 0) setr(0, 1'($urandom_range(1)), AW'($urandom_range(15)));
      if (g_r1 || !bus.r1_req || $urandom_range(15) == 0) setr(1, 1'($urandom_range(1)), AW'($urandom_range(15)));
      rst = ($urandom_range(99) == 0);
      step();
    end
    idle(); rst = 0; repeat (4) step();
    chk("drain", DW'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
